header_shift_loader: RTL and testbench
======================================

Name: header_shift_loader

Overview:
- Stage directly upstream of the mining controller FSM.
- Consumes the byte stream from the UART receiver and hunts for the frame sync pair 0xAA 0x55 while the controller is IDLE.
- Shifts in the 256-bit SHA-256 midstate and the 96-bit remaining header (merkle tail, time, nbits).
- Produces the controller's start_found, midstate_shifts_done and remaining_shifts_done inputs, and holds the loaded words stable for the hash core during SOLVE/HALT.

Parameters:
SYNC0, 8'hAA, first frame sync byte
SYNC1, 8'h55, second frame sync byte
MID_BYTES, 32, bytes of midstate per frame
REM_BYTES, 12, bytes of remaining header per frame

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-high reset
rx_valid  input  1  one-cycle strobe: rx_data holds a new byte
rx_data  input  8  received byte
cur_state  input  3  controller state (IDLE=0, LOAD_MIDSTATE=1, LOAD_REMAINING_HEADER=2, SOLVE=3, HALT=4)
start_found  output  1  one-cycle pulse: sync pair detected
midstate_shifts_done  output  1  level: 32 midstate bytes captured
remaining_shifts_done  output  1  level: 12 header bytes captured
midstate  output  256  captured midstate, first byte at [255:248]
header_tail  output  96  captured header tail, first byte at [95:88]
byte_count  output  6  bytes accepted in current load phase
overrun  output  1  one-cycle pulse: byte dropped

Behaviour:
- Clock and reset: one clock, clk. rst is synchronous and active-high. On rst, all outputs and registers go to 0 and the phase goes to HUNT. A reset mid-frame discards the frame.
- Phases (internal FSM): HUNT, GOT_SYNC0, ARMED, MID, MID_DONE, REM, REM_DONE, HOLD.
- Registering and latency: all outputs are registered. A byte accepted at edge t is visible on midstate/header_tail/byte_count after edge t.
- HUNT (byte with cur_state==IDLE):
  - rx_data==SYNC0 -> GOT_SYNC0.
  - Any other byte -> stay in HUNT.
- GOT_SYNC0 (byte with cur_state==IDLE):
  - SYNC1 -> ARMED, and start_found=1 for exactly one cycle.
  - SYNC0 -> stay in GOT_SYNC0.
  - Any other byte -> HUNT.
- Sync hunting gated on controller: in HUNT or GOT_SYNC0 with cur_state!=IDLE, bytes are ignored, GOT_SYNC0 returns to HUNT, and no overrun is raised.
- ARMED: when cur_state==LOAD_MIDSTATE -> MID with byte_count=0. Otherwise stay. Nominal dwell is 2 cycles.
- MID (per byte):
  - midstate <= {midstate[247:0], rx_data}; byte_count++.
  - On the MID_BYTES-th byte -> MID_DONE and midstate_shifts_done=1.
- MID_DONE: midstate_shifts_done stays high until cur_state==LOAD_REMAINING_HEADER. It then clears, the phase goes to REM, and byte_count=0.
- REM: same as MID but shifting into header_tail. On the REM_BYTES-th byte -> REM_DONE and remaining_shifts_done=1.
- REM_DONE: remaining_shifts_done stays high until cur_state==SOLVE. It then clears and the phase goes to HOLD.
- HOLD: midstate and header_tail are frozen through SOLVE/HALT. Bytes are ignored without overrun. cur_state==IDLE -> HUNT.
- Overrun: a byte arriving in ARMED, MID_DONE or REM_DONE is dropped and pulses overrun. Phase and registers are unchanged.
- Abort: in any of ARMED, MID, MID_DONE, REM or REM_DONE, if cur_state==IDLE for a cycle after ARMED has seen LOAD_MIDSTATE:
  - phase -> HUNT;
  - both done flags cleared, byte_count cleared;
  - data registers retain their contents.
- Simultaneous events: abort has priority over byte acceptance in the same cycle. rst has priority over everything.
- Data registers: a new frame overwrites midstate/header_tail only by shifting. They are never cleared except by rst.

Decomposition:
- Package miner_pkg holds:
  - the controller state_type enum (IDLE..HALT, 3 bits), shared with the controller;
  - the loader phase enum;
  - SYNC0/SYNC1 defaults;
  - MID_BYTES/REM_BYTES defaults.
- One sub-module, byte_shift_reg: parameter WIDTH, with ports clk, rst, shift_en, din[7:0], q[WIDTH-1:0]. It is instantiated twice (WIDTH=256 and WIDTH=96).

Test Plan:
- Basic load:
  - Stimulus: bytes AA,55 with cur_state=IDLE, then a model controller, then bytes 00..1F, then 20..2B.
  - Response: start_found pulses once. midstate=0x00010203…1F. header_tail=0x202122…2B. Done flags each assert after the 32nd/12th byte and clear on the controller's state change.
- Sync false start:
  - Stimulus: AA,AA,55.
  - Response: start_found pulses after the third byte. AA,13,55 -> no pulse.
- Not IDLE:
  - Stimulus: cur_state=SOLVE, bytes AA,55.
  - Response: no start_found, no overrun.
- Overrun:
  - Stimulus: a byte 0x77 arrives in MID_DONE before cur_state==LOAD_REMAINING_HEADER.
  - Response: overrun pulses 1 cycle. midstate is unchanged. The next 12 bytes load header_tail normally.
- Abort:
  - Stimulus: cur_state forced to IDLE after 10 midstate bytes.
  - Response: phase returns to HUNT, byte_count=0, no done flag. A new AA,55 frame loads correctly.
- Reset:
  - Stimulus: rst=1 for one cycle during REM with byte_count=5.
  - Response: every output is 0 the next cycle and the phase is HUNT.

Source files
------------

// File: rtl/miner_pkg.sv
// Shared types and defaults for the mining front end: controller states, loader phases,
// frame sync bytes and frame payload sizes.
package miner_pkg;

    typedef enum logic [2:0] {
        IDLE                  = 3'd0,
        LOAD_MIDSTATE         = 3'd1,
        LOAD_REMAINING_HEADER = 3'd2,
        SOLVE                 = 3'd3,
        HALT                  = 3'd4
    } state_type;

    typedef enum logic [2:0] {
        PhHunt,
        PhGotSync0,
        PhArmed,
        PhMid,
        PhMidDone,
        PhRem,
        PhRemDone,
        PhHold
    } phase_e;

    localparam logic [7:0]  SYNC0_DEF     = 8'hAA;
    localparam logic [7:0]  SYNC1_DEF     = 8'h55;
    localparam int unsigned MID_BYTES_DEF = 32;
    localparam int unsigned REM_BYTES_DEF = 12;

endpackage

// File: rtl/byte_shift_reg.sv
// Byte-wide shift register: each enabled cycle shifts din in at the LSB end, so the first byte
// ends up in the top byte once the register is full.
module byte_shift_reg #(
    parameter int unsigned WIDTH = 256
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             shift_en,
    input  logic [7:0]       din,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else if (shift_en) begin
            q <= {q[WIDTH-9:0], din};
        end
    end

endmodule

// File: rtl/header_shift_loader.sv
// Hunts for the frame sync pair while the controller is idle, then shifts in midstate and
// header tail bytes and raises the controller's handshake flags.
module header_shift_loader
    import miner_pkg::*;
#(
    parameter logic [7:0]  SYNC0     = SYNC0_DEF,
    parameter logic [7:0]  SYNC1     = SYNC1_DEF,
    parameter int unsigned MID_BYTES = MID_BYTES_DEF,
    parameter int unsigned REM_BYTES = REM_BYTES_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         rx_valid,
    input  logic [7:0]   rx_data,
    input  logic [2:0]   cur_state,
    output logic         start_found,
    output logic         midstate_shifts_done,
    output logic         remaining_shifts_done,
    output logic [255:0] midstate,
    output logic [95:0]  header_tail,
    output logic [5:0]   byte_count,
    output logic         overrun
);

    phase_e     phase_q, phase_d;
    logic [5:0] cnt_q, cnt_d;
    logic       start_q, start_d;
    logic       ovr_q, ovr_d;
    logic       mdone_q, mdone_d;
    logic       rdone_q, rdone_d;
    logic       mid_shift, rem_shift;
    state_type  cur_st;
    logic       is_idle;

    assign cur_st  = state_type'(cur_state);
    assign is_idle = (cur_st == IDLE);

    always_comb begin
        phase_d   = phase_q;
        cnt_d     = cnt_q;
        start_d   = 1'b0;
        ovr_d     = 1'b0;
        mdone_d   = mdone_q;
        rdone_d   = rdone_q;
        mid_shift = 1'b0;
        rem_shift = 1'b0;
        unique case (phase_q)
            PhHunt: begin
                if (rx_valid && is_idle && rx_data == SYNC0) phase_d = PhGotSync0;
            end
            PhGotSync0: begin
                if (!is_idle) begin
                    phase_d = PhHunt;
                end else if (rx_valid) begin
                    if (rx_data == SYNC1) begin
                        phase_d = PhArmed;
                        start_d = 1'b1;
                    end else if (rx_data != SYNC0) begin
                        phase_d = PhHunt;
                    end
                end
            end
            PhArmed: begin
                ovr_d = rx_valid;
                if (cur_st == LOAD_MIDSTATE) begin
                    phase_d = PhMid;
                    cnt_d   = '0;
                end
            end
            PhMid, PhRem: begin
                if (is_idle) begin
                    phase_d = PhHunt;
                    cnt_d   = '0;
                    mdone_d = 1'b0;
                    rdone_d = 1'b0;
                end else if (rx_valid) begin
                    cnt_d = cnt_q + 6'd1;
                    if (phase_q == PhMid) begin
                        mid_shift = 1'b1;
                        if (cnt_q == 6'(MID_BYTES - 1)) begin
                            phase_d = PhMidDone;
                            mdone_d = 1'b1;
                        end
                    end else begin
                        rem_shift = 1'b1;
                        if (cnt_q == 6'(REM_BYTES - 1)) begin
                            phase_d = PhRemDone;
                            rdone_d = 1'b1;
                        end
                    end
                end
            end
            PhMidDone, PhRemDone: begin
                // Abort wins over the overrun report for a byte in the same cycle
                if (is_idle) begin
                    phase_d = PhHunt;
                    cnt_d   = '0;
                    mdone_d = 1'b0;
                    rdone_d = 1'b0;
                end else begin
                    ovr_d = rx_valid;
                    if (phase_q == PhMidDone && cur_st == LOAD_REMAINING_HEADER) begin
                        phase_d = PhRem;
                        cnt_d   = '0;
                        mdone_d = 1'b0;
                    end else if (phase_q == PhRemDone && cur_st == SOLVE) begin
                        phase_d = PhHold;
                        rdone_d = 1'b0;
                    end
                end
            end
            PhHold: begin
                if (is_idle) phase_d = PhHunt;
            end
            default: phase_d = PhHunt;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            phase_q <= PhHunt;
            cnt_q   <= '0;
            start_q <= 1'b0;
            ovr_q   <= 1'b0;
            mdone_q <= 1'b0;
            rdone_q <= 1'b0;
        end else begin
            phase_q <= phase_d;
            cnt_q   <= cnt_d;
            start_q <= start_d;
            ovr_q   <= ovr_d;
            mdone_q <= mdone_d;
            rdone_q <= rdone_d;
        end
    end

    byte_shift_reg #(
        .WIDTH (256)
    ) u_mid_sr (
        .clk      (clk),
        .rst      (rst),
        .shift_en (mid_shift),
        .din      (rx_data),
        .q        (midstate)
    );

    byte_shift_reg #(
        .WIDTH (96)
    ) u_rem_sr (
        .clk      (clk),
        .rst      (rst),
        .shift_en (rem_shift),
        .din      (rx_data),
        .q        (header_tail)
    );

    assign start_found           = start_q;
    assign overrun               = ovr_q;
    assign midstate_shifts_done  = mdone_q;
    assign remaining_shifts_done = rdone_q;
    assign byte_count            = cnt_q;

endmodule

// File: tb/tb_header_shift_loader.sv
// Directed bench for header_shift_loader: one task per scenario, inline checks against
// hand-computed values.
module tb_header_shift_loader;

    localparam logic [2:0] C_IDLE  = 3'd0;
    localparam logic [2:0] C_LMID  = 3'd1;
    localparam logic [2:0] C_LREM  = 3'd2;
    localparam logic [2:0] C_SOLVE = 3'd3;

    localparam logic [255:0] MID_00_1F =
        256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [255:0] MID_C0_DF =
        256'hc0c1c2c3c4c5c6c7c8c9cacbcccdcecfd0d1d2d3d4d5d6d7d8d9dadbdcdddedf;
    localparam logic [95:0]  REM_20_2B = 96'h202122232425262728292a2b;
    localparam logic [95:0]  REM_40_4B = 96'h404142434445464748494a4b;

    logic         clk = 1'b0;
    logic         rst;
    logic         rx_valid;
    logic [7:0]   rx_data;
    logic [2:0]   cur_state;
    logic         start_found;
    logic         midstate_shifts_done;
    logic         remaining_shifts_done;
    logic [255:0] midstate;
    logic [95:0]  header_tail;
    logic [5:0]   byte_count;
    logic         overrun;

    int n_cmp = 0;
    int n_err = 0;

    header_shift_loader dut (
        .clk                   (clk),
        .rst                   (rst),
        .rx_valid              (rx_valid),
        .rx_data               (rx_data),
        .cur_state             (cur_state),
        .start_found           (start_found),
        .midstate_shifts_done  (midstate_shifts_done),
        .remaining_shifts_done (remaining_shifts_done),
        .midstate              (midstate),
        .header_tail           (header_tail),
        .byte_count            (byte_count),
        .overrun               (overrun)
    );

    always #5 clk = ~clk;

    // Stimulus helpers: every call returns 1 time unit after a rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        tick();
        rx_valid = 1'b0;
        rx_data  = 8'h00;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic arm_frame();
        cur_state = C_IDLE;
        send_byte(8'hAA);
        send_byte(8'h55);
        cur_state = C_LMID;
        tick();
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++;
        if ({start_found, midstate_shifts_done, remaining_shifts_done, overrun} !== 4'b0) begin
            n_err++;
            $display("FAIL reset_flags: got %b want 0000",
                     {start_found, midstate_shifts_done, remaining_shifts_done, overrun});
        end
        n_cmp++;
        if (midstate !== 256'h0 || header_tail !== 96'h0 || byte_count !== 6'd0) begin
            n_err++;
            $display("FAIL reset_data: mid=%h tail=%h cnt=%0d want all zero",
                     midstate, header_tail, byte_count);
        end
    endtask

    task automatic test_basic_load();
        do_reset();
        cur_state = C_IDLE;
        send_byte(8'hAA);
        n_cmp++;
        if (start_found !== 1'b0) begin
            n_err++; $display("FAIL basic_no_early_start: got %b want 0", start_found);
        end
        send_byte(8'h55);
        n_cmp++;
        if (start_found !== 1'b1) begin
            n_err++; $display("FAIL basic_start_pulse: got %b want 1", start_found);
        end
        tick();
        n_cmp++;
        if (start_found !== 1'b0) begin
            n_err++; $display("FAIL basic_start_one_cycle: got %b want 0", start_found);
        end
        cur_state = C_LMID;
        tick();
        for (int i = 0; i < 31; i++) send_byte(8'(i));
        n_cmp++;
        if (midstate_shifts_done !== 1'b0 || byte_count !== 6'd31) begin
            n_err++;
            $display("FAIL basic_mid_31: done=%b cnt=%0d want done=0 cnt=31",
                     midstate_shifts_done, byte_count);
        end
        send_byte(8'h1F);
        n_cmp++;
        if (midstate_shifts_done !== 1'b1 || byte_count !== 6'd32 || midstate !== MID_00_1F) begin
            n_err++;
            $display("FAIL basic_mid_done: done=%b cnt=%0d mid=%h want 1 32 %h",
                     midstate_shifts_done, byte_count, midstate, MID_00_1F);
        end
        tick();
        n_cmp++;
        if (midstate_shifts_done !== 1'b1) begin
            n_err++; $display("FAIL basic_mid_done_held: got %b want 1", midstate_shifts_done);
        end
        cur_state = C_LREM;
        tick();
        n_cmp++;
        if (midstate_shifts_done !== 1'b0 || byte_count !== 6'd0) begin
            n_err++;
            $display("FAIL basic_mid_clear: done=%b cnt=%0d want 0 0",
                     midstate_shifts_done, byte_count);
        end
        for (int i = 0; i < 12; i++) send_byte(8'(8'h20 + i));
        n_cmp++;
        if (remaining_shifts_done !== 1'b1 || byte_count !== 6'd12 || header_tail !== REM_20_2B) begin
            n_err++;
            $display("FAIL basic_rem_done: done=%b cnt=%0d tail=%h want 1 12 %h",
                     remaining_shifts_done, byte_count, header_tail, REM_20_2B);
        end
        cur_state = C_SOLVE;
        tick();
        n_cmp++;
        if (remaining_shifts_done !== 1'b0) begin
            n_err++; $display("FAIL basic_rem_clear: got %b want 0", remaining_shifts_done);
        end
        send_byte(8'h99);
        n_cmp++;
        if (overrun !== 1'b0 || midstate !== MID_00_1F || header_tail !== REM_20_2B) begin
            n_err++;
            $display("FAIL basic_hold_frozen: ovr=%b mid=%h tail=%h", overrun, midstate,
                     header_tail);
        end
    endtask

    task automatic test_sync_false_start();
        do_reset();
        cur_state = C_IDLE;
        send_byte(8'hAA);
        send_byte(8'hAA);
        n_cmp++;
        if (start_found !== 1'b0) begin
            n_err++; $display("FAIL sync_aa_aa: got %b want 0", start_found);
        end
        send_byte(8'h55);
        n_cmp++;
        if (start_found !== 1'b1) begin
            n_err++; $display("FAIL sync_aa_aa_55: got %b want 1", start_found);
        end
        do_reset();
        send_byte(8'hAA);
        send_byte(8'h13);
        send_byte(8'h55);
        n_cmp++;
        if (start_found !== 1'b0) begin
            n_err++; $display("FAIL sync_aa_13_55: got %b want 0", start_found);
        end
    endtask

    task automatic test_not_idle();
        do_reset();
        cur_state = C_SOLVE;
        send_byte(8'hAA);
        send_byte(8'h55);
        n_cmp++;
        if (start_found !== 1'b0 || overrun !== 1'b0) begin
            n_err++;
            $display("FAIL not_idle: start=%b ovr=%b want 0 0", start_found, overrun);
        end
    endtask

    task automatic test_overrun();
        do_reset();
        arm_frame();
        for (int i = 0; i < 32; i++) send_byte(8'(i));
        send_byte(8'h77);
        n_cmp++;
        if (overrun !== 1'b1 || midstate !== MID_00_1F || byte_count !== 6'd32
            || midstate_shifts_done !== 1'b1) begin
            n_err++;
            $display("FAIL overrun_pulse: ovr=%b mid=%h cnt=%0d done=%b want 1 %h 32 1",
                     overrun, midstate, byte_count, midstate_shifts_done, MID_00_1F);
        end
        tick();
        n_cmp++;
        if (overrun !== 1'b0) begin
            n_err++; $display("FAIL overrun_one_cycle: got %b want 0", overrun);
        end
        cur_state = C_LREM;
        tick();
        for (int i = 0; i < 12; i++) send_byte(8'(8'h40 + i));
        n_cmp++;
        if (header_tail !== REM_40_4B || remaining_shifts_done !== 1'b1) begin
            n_err++;
            $display("FAIL overrun_rem_load: tail=%h done=%b want %h 1", header_tail,
                     remaining_shifts_done, REM_40_4B);
        end
    endtask

    task automatic test_abort();
        do_reset();
        arm_frame();
        for (int i = 0; i < 10; i++) send_byte(8'(i));
        cur_state = C_IDLE;
        tick();
        n_cmp++;
        if (byte_count !== 6'd0 || midstate_shifts_done !== 1'b0
            || midstate !== 256'h00010203040506070809) begin
            n_err++;
            $display("FAIL abort_state: cnt=%0d done=%b mid=%h want 0 0 ..0809",
                     byte_count, midstate_shifts_done, midstate);
        end
        send_byte(8'hAA);
        send_byte(8'h55);
        n_cmp++;
        if (start_found !== 1'b1) begin
            n_err++; $display("FAIL abort_resync: got %b want 1", start_found);
        end
        cur_state = C_LMID;
        tick();
        for (int i = 0; i < 32; i++) send_byte(8'(8'hC0 + i));
        n_cmp++;
        if (midstate !== MID_C0_DF || midstate_shifts_done !== 1'b1) begin
            n_err++;
            $display("FAIL abort_reload: mid=%h done=%b want %h 1", midstate,
                     midstate_shifts_done, MID_C0_DF);
        end
    endtask

    task automatic test_reset_midframe();
        do_reset();
        arm_frame();
        for (int i = 0; i < 32; i++) send_byte(8'(i));
        cur_state = C_LREM;
        tick();
        for (int i = 0; i < 5; i++) send_byte(8'(8'h20 + i));
        n_cmp++;
        if (byte_count !== 6'd5) begin
            n_err++; $display("FAIL rst_mid_precount: got %0d want 5", byte_count);
        end
        do_reset();
        n_cmp++;
        if ({start_found, midstate_shifts_done, remaining_shifts_done, overrun} !== 4'b0
            || midstate !== 256'h0 || header_tail !== 96'h0 || byte_count !== 6'd0) begin
            n_err++;
            $display("FAIL rst_mid_outputs: flags=%b mid=%h tail=%h cnt=%0d want all zero",
                     {start_found, midstate_shifts_done, remaining_shifts_done, overrun},
                     midstate, header_tail, byte_count);
        end
        cur_state = C_IDLE;
        send_byte(8'hAA);
        send_byte(8'h55);
        n_cmp++;
        if (start_found !== 1'b1) begin
            n_err++; $display("FAIL rst_mid_hunt: got %b want 1", start_found);
        end
    endtask

    initial begin
        rst       = 1'b1;
        rx_valid  = 1'b0;
        rx_data   = 8'h00;
        cur_state = C_IDLE;
        tick();
        test_reset();
        test_basic_load();
        test_sync_false_start();
        test_not_idle();
        test_overrun();
        test_abort();
        test_reset_midframe();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
